agc_gain_loop: RTL and testbench

//  Closed-loop AGC: counts ADC samples whose magnitude reaches a threshold over a fixed window.

---
 rtl/agc_gain_loop.sv | 132 +++++++++++++
 tb/tb_agc_gain_loop.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/agc_gain_loop.sv
// Closed-loop AGC: counts threshold hits per sample window, integrates (target - hits)
// into a saturating accumulator and drives the DAC control word v.
module agc_gain_loop #(
  parameter int WIN_LOG2 = 12,
  parameter int FRAC     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  manual,
  input  logic [9:0]            manual_v,
  input  logic [7:0]            threshold,
  input  logic [WIN_LOG2:0]     target,
  input  logic                  sample_valid,
  input  logic [7:0]            sample,
  output logic [9:0]            v,
  output logic                  update,
  output logic                  sat_hi,
  output logic                  sat_lo,
  output logic [WIN_LOG2:0]     last_hits
);

  localparam int AW = 10 + FRAC;
  localparam int SW = AW + 2;
  localparam int EW = WIN_LOG2 + 2;

  typedef enum logic {ACCUM, UPDT} state_t;
  state_t state, state_nx;

  logic [AW-1:0]          acc;
  logic [WIN_LOG2-1:0]    scnt;
  logic [WIN_LOG2:0]      hcnt;
  logic [WIN_LOG2:0]      hcnt_nx;
  logic [WIN_LOG2:0]      hit_latch;
  logic                   upd_d;
  logic [7:0]             mag;
  logic                   hit;
  logic                   run;
  logic                   snap;
  logic signed [EW-1:0]   err;
  logic signed [SW-1:0]   sum;

  always_comb begin
    mag     = sample[7] ? (~sample + 8'd1) : sample;
    hit     = sample_valid & (mag >= threshold);
    run     = enable & ~manual;
    snap    = run & sample_valid & (scnt == '1);
    hcnt_nx = hcnt + {{WIN_LOG2{1'b0}}, hit};
    err     = $signed({1'b0, target}) - $signed({1'b0, hit_latch});
    sum     = $signed({2'b00, acc}) + $signed({{(SW-EW){err[EW-1]}}, err});
  end

  // pend is represented by the UPDT state; leaving run mode drops it
  always_comb begin
    state_nx = state;
    if (!run)
      state_nx = ACCUM;
    else if (snap)
      state_nx = UPDT;
    else if (state == UPDT)
      state_nx = ACCUM;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ACCUM;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= {10'd512, {FRAC{1'b0}}};
      v         <= 10'd512;
      update    <= 1'b0;
      upd_d     <= 1'b0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
      hit_latch <= '0;
      scnt      <= '0;
      hcnt      <= '0;
    end else if (manual) begin
      acc    <= {manual_v, {FRAC{1'b0}}};
      v      <= manual_v;
      update <= 1'b0;
      upd_d  <= 1'b0;
      sat_hi <= 1'b0;
      sat_lo <= 1'b0;
      scnt   <= '0;
      hcnt   <= '0;
    end else if (!enable) begin
      update <= 1'b0;
      upd_d  <= 1'b0;
      scnt   <= '0;
      hcnt   <= '0;
    end else begin
      update <= upd_d;
      upd_d  <= 1'b0;
      if (upd_d)
        v <= acc[AW-1:FRAC];
      if (sample_valid) begin
        if (snap) begin
          hit_latch <= hcnt_nx;
          scnt      <= '0;
          hcnt      <= '0;
        end else begin
          scnt <= scnt + 1'b1;
          hcnt <= hcnt_nx;
        end
      end
      if (state == UPDT) begin
        upd_d <= 1'b1;
        if (sum[SW-1]) begin
          acc    <= '0;
          sat_lo <= 1'b1;
          sat_hi <= 1'b0;
        end else if (sum[AW]) begin
          acc    <= '1;
          sat_hi <= 1'b1;
          sat_lo <= 1'b0;
        end else begin
          acc    <= sum[AW-1:0];
          sat_hi <= 1'b0;
          sat_lo <= 1'b0;
        end
      end
    end
  end

  assign last_hits = hit_latch;

endmodule

// File: tb/tb_agc_gain_loop.sv
// Scoreboard bench for agc_gain_loop: an arithmetic window/accumulator model queues the
// expected result of every completed window; a monitor checks each update pulse.
module tb_agc_gain_loop;
  localparam int W = 4;
  localparam int F = 2;
  localparam int ACC_MAX = (1 << (10 + F)) - 1;

  logic         clk = 1'b0;
  logic         reset, enable, manual, sample_valid;
  logic [9:0]   manual_v;
  logic [7:0]   threshold, sample;
  logic [W:0]   target;
  logic [9:0]   v;
  logic         update, sat_hi, sat_lo;
  logic [W:0]   last_hits;

  always #5 clk = ~clk;

  agc_gain_loop #(.WIN_LOG2(W), .FRAC(F)) dut (
    .clk(clk), .reset(reset), .enable(enable), .manual(manual), .manual_v(manual_v),
    .threshold(threshold), .target(target), .sample_valid(sample_valid), .sample(sample),
    .v(v), .update(update), .sat_hi(sat_hi), .sat_lo(sat_lo), .last_hits(last_hits)
  );

  typedef struct {
    int     v;
    int     sh;
    int     sl;
    int     lh;
    longint edge_n;
  } exp_t;

  exp_t   q[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     m_acc, m_cnt, m_hits, m_sh, m_sl;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour applied at each rising edge using the inputs present at that edge
  task automatic model(input longint e);
    int s, mag, sum;
    if (reset) begin
      m_acc = 2048; m_cnt = 0; m_hits = 0; m_sh = 0; m_sl = 0;
    end else if (manual) begin
      m_acc = int'(manual_v) * (1 << F); m_cnt = 0; m_hits = 0; m_sh = 0; m_sl = 0;
    end else if (!enable) begin
      m_cnt = 0; m_hits = 0;
    end else if (sample_valid) begin
      s   = sample[7] ? int'(sample) - 256 : int'(sample);
      mag = (s < 0) ? -s : s;
      if (mag >= int'(threshold)) m_hits++;
      m_cnt++;
      if (m_cnt == (1 << W)) begin
        sum = m_acc + int'(target) - m_hits;
        m_sh = 0; m_sl = 0;
        if (sum < 0) begin
          m_acc = 0; m_sl = 1;
        end else if (sum > ACC_MAX) begin
          m_acc = ACC_MAX; m_sh = 1;
        end else begin
          m_acc = sum;
        end
        q.push_back('{v: m_acc / (1 << F), sh: m_sh, sl: m_sl, lh: m_hits, edge_n: e + 2});
        m_cnt = 0; m_hits = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model(cyc);
    #1;
  endtask

  task automatic send(input logic val, input logic [7:0] s);
    sample_valid = val;
    sample       = s;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() != 0; i++) send(1'b0, 8'd0);
    if (q.size() != 0) begin
      check("drain_pending", q.size(), 0);
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && update) begin
      if (q.size() == 0) begin
        check("spurious_update", 1, 0);
      end else begin
        e = q.pop_front();
        check("upd_v", int'(v), e.v);
        check("upd_sat_hi", int'(sat_hi), e.sh);
        check("upd_sat_lo", int'(sat_lo), e.sl);
        check("upd_last_hits", int'(last_hits), e.lh);
        check("upd_latency_edge", int'(cyc - 1), int'(e.edge_n));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; manual = 1'b0; manual_v = '0;
    threshold = 8'd64; target = 5'd8; sample_valid = 1'b0; sample = '0;
    tick(); tick();
    check("rst_v", int'(v), 512);
    check("rst_update", int'(update), 0);
    check("rst_sat_hi", int'(sat_hi), 0);
    check("rst_sat_lo", int'(sat_lo), 0);
    check("rst_last_hits", int'(last_hits), 0);
    reset = 1'b0;
    send(1'b0, 8'd0);

    // 16 strong samples: all hits, v 512 -> 510
    for (int i = 0; i < 16; i++) send(1'b1, 8'd100);
    drain();
    check("strong_v", int'(v), 510);

    // Quiet input drives v up to the ceiling and holds it there
    for (int i = 0; i < 262 * 16; i++) send(1'b1, 8'd0);
    drain();
    check("ceil_v", int'(v), 1023);
    check("ceil_sat_hi", int'(sat_hi), 1);

    // Magnitude edge: -128 reaches threshold 128, +127 does not
    threshold = 8'd128;
    for (int i = 0; i < 16; i++) send(1'b1, (i % 2 == 0) ? 8'h80 : 8'h7f);
    drain();
    check("edge_last_hits", int'(last_hits), 8);
    check("edge_v", int'(v), 1023);

    // Two back-to-back windows, then a window stretched by gaps
    threshold = 8'd64; target = 5'd10;
    for (int i = 0; i < 32; i++) send(1'b1, (i % 3 == 0) ? 8'd90 : 8'd5);
    drain();
    for (int i = 0; i < 16; ) begin
      if ($urandom_range(1, 0) == 1) begin
        send(1'b1, (i % 2 == 0) ? 8'hb0 : 8'd10);
        i++;
      end else begin
        send(1'b0, 8'd100);
      end
    end
    drain();

    // Manual override and bumpless return with hits equal to target
    target = 5'd8; manual = 1'b1; manual_v = 10'd300;
    send(1'b0, 8'd0);
    check("manual_v", int'(v), 300);
    check("manual_update", int'(update), 0);
    check("manual_sat_hi", int'(sat_hi), 0);
    manual = 1'b0;
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 16; i++) send(1'b1, (i < 8) ? 8'd100 : 8'd0);
    drain();
    check("manual_hold_v", int'(v), 300);

    // Floor clip: small v, zero target, all hits
    manual = 1'b1; manual_v = 10'd2; send(1'b0, 8'd0);
    manual = 1'b0; target = 5'd0;
    for (int i = 0; i < 16; i++) send(1'b1, 8'd120);
    drain();
    check("floor_v", int'(v), 0);
    check("floor_sat_lo", int'(sat_lo), 1);

    // Reset mid-window discards the partial count
    target = 5'd8;
    for (int i = 0; i < 7; i++) send(1'b1, 8'd100);
    reset = 1'b1; send(1'b1, 8'd100);
    check("midrst_v", int'(v), 512);
    check("midrst_last_hits", int'(last_hits), 0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) send(1'b1, 8'd100);
    drain();
    check("midrst_v_after", int'(v), 510);

    // Randomized traffic with freezes between windows
    for (int blk = 0; blk < 8; blk++) begin
      target = 5'($urandom_range(16, 0));
      for (int c = 0; c < 60; c++) begin
        enable = !(q.size() == 0 && $urandom_range(9, 0) == 0);
        case ($urandom_range(3, 0))
          0: threshold = 8'd0;
          1: threshold = 8'd128;
          default: threshold = 8'($urandom_range(127, 1));
        endcase
        send(1'($urandom_range(3, 0) != 0), 8'($urandom));
      end
      enable = 1'b1;
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
